// File: rtl/rotate_right_if.sv
// rotate_right_if: request/result bundle between the ALU issue logic and the shift/rotate lane.
// Latency: n/a (wiring only); carries the request sampled on en and the registered result.
// Backpressure: none; the master drives requests, the slave returns out/out_valid one cycle later.

interface rotate_right_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);

   logic               en;
   logic [1:0]         op;
   logic [WIDTH-1:0]   source_1;
   logic [SHAMT_W-1:0] number_bits;
   logic [WIDTH-1:0]   out;
   logic               out_valid;

   // Issue side: drives the request, observes the result
   modport master (
      output en,
      output op,
      output source_1,
      output number_bits,
      input  out,
      input  out_valid
   );

   // Execution side: the shift/rotate unit itself
   modport slave (
      input  en,
      input  op,
      input  source_1,
      input  number_bits,
      output out,
      output out_valid
   );

endinterface

// File: rtl/rotate_right.sv
// rotate_right: registered 32-bit shift-left / shift-right / rotate-right lane; SHIFT_ARITH_EN makes op 2'b11 an arithmetic right shift.
// Latency: 1 cycle from en to out/out_valid; one operation per cycle, back-to-back supported.
// Backpressure: none; every accepted en produces a one-cycle out_valid pulse, reset drops a coincident request.

module rotate_right #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic          clk,
   input  logic          reset,
   rotate_right_if.slave bus
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_ROR = 2'b10;
   localparam logic [1:0] OP_ALT = 2'b11;

   logic [WIDTH-1:0] barrel_res;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_d;
   logic             out_valid_q;

   // One barrel stage: move v by the constant distance k according to op.
   // The arithmetic fill reads v's own MSB, which every earlier stage has
   // preserved, so it always equals the original operand's sign bit.
   function automatic logic [WIDTH-1:0] stage_shift(
      input logic [1:0]       op,
      input logic [WIDTH-1:0] v,
      input int               k
   );
      logic [WIDTH-1:0] r;
      r = v;
      case (op)
         OP_SLL: r = v << k;
         OP_SRL: r = v >> k;
         OP_ROR: r = (v >> k) | (v << (WIDTH - k));
`ifdef SHIFT_ARITH_EN
         OP_ALT: r = (v >> k) | ({WIDTH{v[WIDTH-1]}} << (WIDTH - k));
`else
         // Without the arithmetic option op 2'b11 is a plain pass-through
         OP_ALT: r = v;
`endif
      endcase
      return r;
   endfunction

   // Logarithmic barrel: stage i moves by 2**i when amount bit i is set.
   // The amount port is exactly SHAMT_W bits, so wider values arrive
   // already truncated and need no saturation here.
   always_comb begin
      barrel_res = bus.source_1;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (bus.number_bits[i]) begin
            barrel_res = stage_shift(bus.op, barrel_res, 1 << i);
         end
      end
   end

   // Next state: capture a new result on en, otherwise hold the last one
   always_comb begin
      out_d       = out_q;
      out_valid_d = 1'b0;
      if (bus.en) begin
         out_d       = barrel_res;
         out_valid_d = 1'b1;
      end
   end

   // Result register; reset wins over a simultaneous request
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rotate_right.sv
// tb_rotate_right: directed and random checks of the shift/rotate lane against a bit-level reference model.
// Latency: expects each request's result one cycle after the sampling edge.
// Backpressure: none exercised; the bench issues requests every cycle or idles.

module tb_rotate_right;

   logic clk;
   logic reset;
   int   checks;
   int   fails;

   logic [31:0] exp_out;
   logic        exp_vld;

   rotate_right_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

   rotate_right #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: each result bit is picked from the operand by position,
   // using the amount reduced to its low five bits.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] src, input int amt);
      logic [31:0] r;
      int          n;
      n = amt & 31;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         case (op)
            2'b00: r[i] = (i >= n) ? src[i - n] : 1'b0;
            2'b01: r[i] = (i + n < 32) ? src[i + n] : 1'b0;
            2'b10: r[i] = src[(i + n) % 32];
`ifdef SHIFT_ARITH_EN
            2'b11: r[i] = (i + n < 32) ? src[i + n] : src[31];
`else
            2'b11: r[i] = src[i];
`endif
         endcase
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock: drive at negedge, sample 1ns after the rising edge.
   // If use_lit is set the literal overrides the model for a valid result.
   task automatic step(input string tag, input logic rst, input logic en, input logic [1:0] op,
                       input logic [31:0] src, input int amt,
                       input logic use_lit, input logic [31:0] lit);
      @(negedge clk);
      reset           = rst;
      bus.en          = en;
      bus.op          = op;
      bus.source_1    = src;
      bus.number_bits = amt[4:0];
      if (rst) begin
         exp_out = 32'h0;
         exp_vld = 1'b0;
      end else if (en) begin
         exp_out = use_lit ? lit : model(op, src, amt);
         exp_vld = 1'b1;
      end else begin
         exp_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      check({tag, ".out"}, bus.out, exp_out);
      check({tag, ".vld"}, {31'b0, bus.out_valid}, {31'b0, exp_vld});
   endtask

   initial begin
      logic [31:0] lit_arith;
      checks          = 0;
      fails           = 0;
      exp_out         = '0;
      exp_vld         = 1'b0;
      reset           = 1'b1;
      bus.en          = 1'b0;
      bus.op          = 2'b00;
      bus.source_1    = '0;
      bus.number_bits = '0;

      // Reset wins over a request presented in the same cycle
      step("rst_en", 1, 1, 2'b00, 32'hFFFFFFFF, 0, 0, 0);

      // Shift left, back-to-back, including truncated amount 32
      step("sll0",  0, 1, 2'b00, 32'hFFFFFFFF, 0,  1, 32'hFFFFFFFF);
      step("sll1",  0, 1, 2'b00, 32'hFFFFFFFF, 1,  1, 32'hFFFFFFFE);
      step("sll2",  0, 1, 2'b00, 32'hFFFFFFFF, 2,  1, 32'hFFFFFFFC);
      step("sll3",  0, 1, 2'b00, 32'hFFFFFFFF, 3,  1, 32'hFFFFFFF8);
      step("sll31", 0, 1, 2'b00, 32'hFFFFFFFF, 31, 1, 32'h80000000);
      step("sll32", 0, 1, 2'b00, 32'hFFFFFFFF, 32, 1, 32'hFFFFFFFF);

      // Shift right logical
      step("srl0",  0, 1, 2'b01, 32'hFFFFFFFF, 0,  1, 32'hFFFFFFFF);
      step("srl1",  0, 1, 2'b01, 32'hFFFFFFFF, 1,  1, 32'h7FFFFFFF);
      step("srl2",  0, 1, 2'b01, 32'hFFFFFFFF, 2,  1, 32'h3FFFFFFF);
      step("srl3",  0, 1, 2'b01, 32'hFFFFFFFF, 3,  1, 32'h1FFFFFFF);
      step("srl31", 0, 1, 2'b01, 32'hFFFFFFFF, 31, 1, 32'h00000001);
      step("srl32", 0, 1, 2'b01, 32'hFFFFFFFF, 32, 1, 32'hFFFFFFFF);

      // Rotate right
      step("ror0",  0, 1, 2'b10, 32'hFFFF0000, 0,  1, 32'hFFFF0000);
      step("ror1",  0, 1, 2'b10, 32'hFFFF0000, 1,  1, 32'h7FFF8000);
      step("ror2",  0, 1, 2'b10, 32'hFFFF0000, 2,  1, 32'h3FFFC000);
      step("ror3",  0, 1, 2'b10, 32'hFFFF0000, 3,  1, 32'h1FFFE000);
      step("ror31", 0, 1, 2'b10, 32'hFFFF0000, 31, 1, 32'hFFFE0001);
      step("rorl1", 0, 1, 2'b10, 32'h0000FFFF, 1,  1, 32'h80007FFF);
      step("rorl2", 0, 1, 2'b10, 32'h0000FFFF, 2,  1, 32'hC0003FFF);

      // op 11: arithmetic shift or pass-through depending on the build
`ifdef SHIFT_ARITH_EN
      lit_arith = 32'hF8000000;
`else
      lit_arith = 32'h80000000;
`endif
      step("op11", 0, 1, 2'b11, 32'h80000000, 4, 1, lit_arith);

      // Idle: result holds, valid drops
      step("hold1", 0, 0, 2'b00, 32'h12345678, 7, 0, 0);
      step("hold2", 0, 0, 2'b01, 32'hDEADBEEF, 9, 0, 0);

      // Reset mid-stream, then three back-to-back requests and idle
      step("rst_mid", 1, 1, 2'b10, 32'hA5A5A5A5, 5, 0, 0);
      step("rst_rel", 0, 0, 2'b00, 32'hFFFFFFFF, 0, 0, 0);
      step("b2b_a",   0, 1, 2'b00, 32'h0000000F, 4, 1, 32'h000000F0);
      step("b2b_b",   0, 1, 2'b01, 32'hF0000000, 4, 1, 32'h0F000000);
      step("b2b_c",   0, 1, 2'b10, 32'h00000001, 1, 1, 32'h80000000);
      step("b2b_idle", 0, 0, 2'b00, 32'h0, 0, 0, 0);

      // Random requests, idles and occasional resets against the model
      for (int k = 0; k < 400; k++) begin
         logic        r_rst;
         logic        r_en;
         logic [1:0]  r_op;
         logic [31:0] r_src;
         int          r_amt;
         r_rst = ($urandom_range(0, 29) == 0);
         r_en  = ($urandom_range(0, 3) != 0);
         r_op  = 2'($urandom_range(0, 3));
         r_src = $urandom;
         r_amt = $urandom_range(0, 32);
         step("rand", r_rst, r_en, r_op, r_src, r_amt, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/rotate_right.md
# rotate_right

Registered 32-bit shift/rotate unit for the ALU datapath. It implements three operations on a 32-bit operand by a 5-bit amount: logical shift left, logical shift right, and rotate right. The result is registered one clock after the request and feeds the ALU result multiplexer as the shift/rotate lane.

## Interface

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- SHAMT_W, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  request strobe; the operands are sampled when en=1.
- op  input  2  operation select: 2'b00 shift left, 2'b01 shift right logical, 2'b10 rotate right, 2'b11 see Configuration.
- source_1  input  WIDTH  operand.
- number_bits  input  SHAMT_W  amount, 0..31, unsigned.
- out  output  WIDTH  registered result.
- out_valid  output  1  high for one cycle when out carries a new result.

## Operation

- Shift left (00): out = source_1 << number_bits. Vacated LSBs are zero-filled.
- Shift right (01): out = source_1 >> number_bits. Vacated MSBs are zero-filled.
- Rotate right (10): out = (source_1 >> n) | (source_1 << (32-n)). Bits leaving the LSB re-enter at the MSB.
- number_bits = 0: out = source_1 for every op.
- The amount is strictly 5 bits. A value of 32 presented by a wider driver truncates to 0, so the result is the unmodified operand. The block performs no saturation and no modulo beyond the 5-bit truncation.
- Implementation is a 5-stage logarithmic barrel (1/2/4/8/16), combinational ahead of the output register. The block contains no iterative/multi-cycle state machine.
- With en=0 the registers hold out; out_valid=0.

## Timing

- Latency 1 cycle: inputs sampled on edge k with en=1 -> out valid after edge k, out_valid=1 for exactly that cycle.
- Throughput: one operation per cycle. Back-to-back en produces back-to-back results.
- Reset: on a rising edge with reset=1, out=32'h0 and out_valid=0. Reset takes priority over a simultaneous en.
- Reset mid-stream: a request presented in the same cycle as reset is dropped, with no result produced afterwards.
- Inputs need only be stable around the sampling edge. There is no handshake back-pressure.

## Configuration

- SHIFT_ARITH_EN defined: op=2'b11 performs an arithmetic shift right. Vacated MSBs are filled with source_1[31].
- SHIFT_ARITH_EN undefined: op=2'b11 passes source_1 through unchanged, with no arithmetic logic synthesized.
- Ops 00/01/10 are identical in both builds.

## Test plan

- Shift left of 32'hFFFFFFFF by 0/1/2/3/31 -> FFFFFFFF, FFFFFFFE, FFFFFFFC, FFFFFFF8, 80000000, each one cycle after en. Amount 32 truncated to 0 -> FFFFFFFF.
- Shift right of 32'hFFFFFFFF by 0/1/2/3/31 -> FFFFFFFF, 7FFFFFFF, 3FFFFFFF, 1FFFFFFF, 00000001. Amount 32 truncated to 0 -> FFFFFFFF.
- Rotate right of 32'hFFFF0000 by 0/1/2/3/31 -> FFFF0000, 7FFF8000, 3FFFC000, 1FFFE000, FFFE0001. Rotate right of 32'h0000FFFF by 1/2 -> 80007FFF, C0003FFF.
- Reset: assert reset with en=1, op=00, source_1=FFFFFFFF -> out=0, out_valid=0 next cycle. Release reset and issue three back-to-back requests -> three consecutive valid results in order. With en=0 afterwards, out holds the last result and out_valid=0.
- op=11 with source_1=32'h80000000, number_bits=4 -> F8000000 with SHIFT_ARITH_EN, 80000000 without.
